// File: rtl/crp16_boot_controller.sv
// CRP16 boot controller: loads a program image into dual-port RAM, then hands the RAM to the CPU datapath.
// Optional build macro CRP16_BOOT_CHECKSUM_EN adds a 16-bit running sum of the loaded words.
module crp16_boot_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        load_done,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic [15:0] cpu_instr_view,
    input  logic [15:0] cpu_address_a,
    input  logic [15:0] cpu_address_b,
    input  logic [15:0] cpu_data_a,
    input  logic [15:0] cpu_data_b,
    input  logic        cpu_wren_a,
    input  logic        cpu_wren_b,
    output logic [15:0] cpu_q_a,
    output logic [15:0] cpu_q_b,
    output logic [15:0] address_a,
    output logic [15:0] address_b,
    output logic [15:0] data_a,
    output logic [15:0] data_b,
    output logic        wren_a,
    output logic        wren_b,
    input  logic [15:0] q_a,
    input  logic [15:0] q_b,
    input  logic [15:0] dbg_addr,
    output logic [15:0] dbg_q,
    output logic        cpu_reset,
    output logic [1:0]  state,
    output logic [15:0] load_count,
    output logic        load_wrap,
    output logic [15:0] load_checksum
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD    = 2'b01,
        ST_RUN     = 2'b10,
        ST_STOPPED = 2'b11
    } state_t;

    localparam logic [15:0] STOP_INSTR = 16'h8000;

    state_t      state_q;
    logic [15:0] load_count_q;
    logic [15:0] load_count_d;
    logic        load_wrap_q;
    logic        run_mode;
    logic        accept;
    logic        enter_load;

    // Loader handshake: a word moves when load_valid and load_ready are both high in the
    // same cycle; load_ready is high only in LOAD and is forced low while reset is sampled,
    // so an in-flight word is neither written nor counted.
    assign run_mode     = (state_q == ST_RUN);
    assign load_ready   = (state_q == ST_LOAD) && !reset;
    assign accept       = load_valid && load_ready;
    assign load_count_d = load_count_q + 16'd1;
    assign enter_load   = !reset && load_start &&
                          ((state_q == ST_IDLE) || ((state_q == ST_STOPPED) && !halt_req));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            load_count_q <= 16'h0000;
            load_wrap_q  <= 1'b0;
        end else begin
            if (accept) begin
                load_count_q <= load_count_d;
                if (load_count_q == 16'hFFFF) begin
                    load_wrap_q <= 1'b1;
                end
            end
            if (enter_load) begin
                load_count_q <= 16'h0000;
                load_wrap_q  <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                    end else if (run_req) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (load_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_q <= ST_IDLE;
                    end else if (cpu_instr_view == STOP_INSTR) begin
                        state_q <= ST_STOPPED;
                    end
                end
                ST_STOPPED: begin
                    if (halt_req) begin
                        state_q <= ST_IDLE;
                    end else if (load_start) begin
                        state_q <= ST_LOAD;
                    end else if (run_req) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CRP16_BOOT_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clock) begin
        if (reset || enter_load) begin
            checksum_q <= 16'h0000;
        end else if (accept) begin
            checksum_q <= checksum_q + load_data;
        end
    end

    assign load_checksum = checksum_q;
`else
    assign load_checksum = 16'h0000;
`endif

    // Datapath owns both RAM ports only while running; otherwise port A is the loader and port B is debug readback.
    assign address_a = run_mode ? cpu_address_a : load_count_q;
    assign data_a    = run_mode ? cpu_data_a    : load_data;
    assign wren_a    = run_mode ? (cpu_wren_a && !reset) : accept;
    assign address_b = run_mode ? cpu_address_b : dbg_addr;
    assign data_b    = run_mode ? cpu_data_b    : 16'h0000;
    assign wren_b    = run_mode && cpu_wren_b && !reset;

    assign cpu_q_a    = q_a;
    assign cpu_q_b    = q_b;
    assign dbg_q      = q_b;
    assign cpu_reset  = !run_mode || reset;
    assign state      = state_q;
    assign load_count = load_count_q;
    assign load_wrap  = load_wrap_q;

endmodule
